// File: rtl/phase_prog_decoder_if.sv
// Connection bundle between the serial programming decoder and its neighbours:
// the serial line in, the phase word/strobes out, plus an FSM state debug tap.
interface phase_prog_decoder_if #(
    parameter int NUM_SIZE = 7
);
    logic                decoderInput;
    logic [NUM_SIZE-1:0] phase_num;
    logic                num_valid;
    logic                frame_err;
    logic                busy;
    logic [2:0]          dbgState;

    // num_valid is a one-cycle strobe with no ready: the consumer must take
    // phase_num in the same cycle num_valid is high; phase_num then holds.
    modport master (
        output decoderInput,
        input  phase_num, num_valid, frame_err, busy, dbgState
    );

    modport slave (
        input  decoderInput,
        output phase_num, num_valid, frame_err, busy, dbgState
    );
endinterface

// File: rtl/phase_prog_decoder.sv
// Framed MSB-first serial decoder producing the phase delay word for the delay stage.
// Define DECODER_PARITY_EN to require a trailing even-parity bit on every frame.
module phase_prog_decoder #(
    parameter int                  NUM_SIZE    = 7,
    parameter int                  HDR_SIZE    = 4,
    parameter logic [HDR_SIZE-1:0] HEADER      = 4'b0100,
    parameter int                  BIT_CLKS    = 512,
    parameter int                  SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst,
    phase_prog_decoder_if.slave bus
);
    localparam int SEQ_SIZE = HDR_SIZE + NUM_SIZE;
    localparam int CNT_W    = $clog2(BIT_CLKS);
    localparam int IDX_W    = $clog2(SEQ_SIZE);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CLKS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CLKS - 1);
    localparam logic [IDX_W-1:0] IDX_LOAD  = IDX_W'(SEQ_SIZE - 1);

`ifdef DECODER_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, CHECK = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, CHECK = 3'd4} state_t;
`endif

    state_t               state;
    state_t               stateNext;
    logic [SYNC_STAGES-1:0] syncReg;
    logic                 syncIn;
    logic                 syncPrev;
    logic                 startEdge;
    logic [CNT_W-1:0]     bitCnt;
    logic                 tick;
    logic [IDX_W-1:0]     bitIdx;
    logic [SEQ_SIZE-1:0]  shiftReg;
    logic [SEQ_SIZE-1:0]  shiftNext;
    logic [SEQ_SIZE-1:0]  checkWord;
    logic                 lastSample;
    logic                 frameOk;
    logic [NUM_SIZE-1:0]  phaseNum;
    logic                 numValid;
    logic                 frameErr;

    assign syncIn    = syncReg[SYNC_STAGES-1];
    assign startEdge = syncIn & ~syncPrev;
    assign tick      = (bitCnt == '0);
    assign shiftNext = {shiftReg[SEQ_SIZE-2:0], syncIn};

    // The verdict is formed on the final sampling edge so the word and its
    // strobe appear together in the CHECK cycle.
`ifdef DECODER_PARITY_EN
    assign checkWord  = shiftReg;
    assign lastSample = (state == PARITY) && tick;
    assign frameOk    = (checkWord[SEQ_SIZE-1 -: HDR_SIZE] == HEADER) &&
                        ((^checkWord ^ syncIn) == 1'b0);
`else
    assign checkWord  = shiftNext;
    assign lastSample = (state == DATA) && tick && (bitIdx == '0);
    assign frameOk    = (checkWord[SEQ_SIZE-1 -: HDR_SIZE] == HEADER);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncReg  <= '0;
            syncPrev <= 1'b0;
        end else begin
            syncReg  <= {syncReg[SYNC_STAGES-2:0], bus.decoderInput};
            syncPrev <= syncIn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (startEdge) stateNext = START;
            START: if (tick) stateNext = syncIn ? DATA : IDLE;
`ifdef DECODER_PARITY_EN
            DATA:   if (tick && (bitIdx == '0)) stateNext = PARITY;
            PARITY: if (tick) stateNext = CHECK;
`else
            DATA:   if (tick && (bitIdx == '0)) stateNext = CHECK;
`endif
            CHECK: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            phaseNum <= '0;
            numValid <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            numValid <= 1'b0;
            frameErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (startEdge) begin
                        bitCnt   <= HALF_LOAD;
                        shiftReg <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        bitCnt <= FULL_LOAD;
                        bitIdx <= IDX_LOAD;
                    end else begin
                        bitCnt <= bitCnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        bitCnt   <= FULL_LOAD;
                        shiftReg <= shiftNext;
                        if (bitIdx != '0) bitIdx <= bitIdx - IDX_W'(1);
                    end else begin
                        bitCnt <= bitCnt - CNT_W'(1);
                    end
                end
`ifdef DECODER_PARITY_EN
                PARITY: begin
                    if (tick) bitCnt <= FULL_LOAD;
                    else      bitCnt <= bitCnt - CNT_W'(1);
                end
`endif
                default: ;
            endcase
            if (lastSample) begin
                if (frameOk) begin
                    phaseNum <= checkWord[NUM_SIZE-1:0];
                    numValid <= 1'b1;
                end else begin
                    frameErr <= 1'b1;
                end
            end
        end
    end

    assign bus.phase_num = phaseNum;
    assign bus.num_valid = numValid;
    assign bus.frame_err = frameErr;
    assign bus.busy      = (state != IDLE);
    assign bus.dbgState  = state;
endmodule

// File: tb/tb_phase_prog_decoder.sv
// Directed bench for phase_prog_decoder: drives serial frames bit by bit and
// checks strobes, held phase word, latency, glitch rejection and reset.
module tb_phase_prog_decoder;
  localparam int NUM_SIZE    = 7;
  localparam int HDR_SIZE    = 4;
  localparam int SEQ_SIZE    = HDR_SIZE + NUM_SIZE;
  localparam int BIT_CLKS    = 512;
  localparam int SYNC_STAGES = 2;
`ifdef DECODER_PARITY_EN
  localparam int NBITS = SEQ_SIZE + 1;
`else
  localparam int NBITS = SEQ_SIZE;
`endif
  // clocks from the launch edge of the start bit to the edge raising num_valid
  localparam int EXP_LAT = SYNC_STAGES + 1 + BIT_CLKS / 2 + NBITS * BIT_CLKS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  phase_prog_decoder_if #(.NUM_SIZE(NUM_SIZE)) busIf();

  phase_prog_decoder #(
    .NUM_SIZE(NUM_SIZE), .HDR_SIZE(HDR_SIZE), .HEADER(4'b0100),
    .BIT_CLKS(BIT_CLKS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(busIf.slave)
  );

  // clock / reset block
  always #25 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [NUM_SIZE-1:0] exp_q[$];
  logic [NUM_SIZE-1:0] got_q[$];
  int   validCount = 0;
  int   errCount = 0;
  int   validCyc = 0;
  int   startCyc = 0;
  logic prevValid = 1'b0;
  logic prevErr = 1'b0;
  logic bothHigh = 1'b0;
  logic longPulse = 1'b0;

  always @(negedge clk) begin
    if (busIf.num_valid) begin
      if (!prevValid) begin
        validCount++;
        got_q.push_back(busIf.phase_num);
        validCyc = cyc;
      end else begin
        longPulse = 1'b1;
      end
    end
    if (busIf.frame_err) begin
      if (!prevErr) errCount++;
      else longPulse = 1'b1;
    end
    if (busIf.num_valid && busIf.frame_err) bothHigh = 1'b1;
    prevValid = busIf.num_valid;
    prevErr   = busIf.frame_err;
  end

  // driver tasks
  task automatic drive_bit(input logic b, input int w);
    busIf.decoderInput = b;
    repeat (w) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [HDR_SIZE-1:0] hdr, input logic [NUM_SIZE-1:0] num,
                            input int w, input logic parityFlip);
    logic [SEQ_SIZE-1:0] seq;
    logic                parBit;
    seq    = {hdr, num};
    parBit = (^seq) ^ parityFlip;
    @(posedge clk);
    #1;
    startCyc = cyc;
    drive_bit(1'b1, w);
    for (int i = SEQ_SIZE - 1; i >= 0; i--) drive_bit(seq[i], w);
`ifdef DECODER_PARITY_EN
    drive_bit(parBit, w);
`else
    if (parBit === 1'bx) busIf.decoderInput = 1'b0;
`endif
  endtask

  task automatic test_reset();
    busIf.decoderInput = 1'b0;
    #10 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busIf.phase_num !== 7'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", busIf.phase_num); end
    checks++; if (busIf.num_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", busIf.num_valid); end
    checks++; if (busIf.frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", busIf.frame_err); end
    checks++; if (busIf.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busIf.busy); end
    checks++; if (busIf.dbgState !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", busIf.dbgState); end
    rst = 1'b0;
    drive_bit(1'b0, 8);
  endtask

  task automatic test_valid_frame();
    int v0, e0;
    logic [NUM_SIZE-1:0] expv, gotv;
    v0 = validCount; e0 = errCount;
    exp_q.push_back(7'd32);
    send_frame(4'b0100, 7'd32, BIT_CLKS, 1'b0);
    drive_bit(1'b0, 2 * BIT_CLKS);
    checks++; if (validCount - v0 !== 1) begin failures++; $display("FAIL valid_count got=%0d exp=1", validCount - v0); end
    checks++; if (errCount !== e0) begin failures++; $display("FAIL valid_err got=%0d exp=0", errCount - e0); end
    expv = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0) begin failures++; $display("FAIL valid_word got=none exp=%0d", expv); end
    else begin
      gotv = got_q.pop_front();
      if (gotv !== expv) begin failures++; $display("FAIL valid_word got=%0d exp=%0d", gotv, expv); end
    end
    checks++; if (busIf.phase_num !== 7'd32) begin failures++; $display("FAIL valid_hold got=%0d exp=32", busIf.phase_num); end
    checks++; if (validCyc - startCyc !== EXP_LAT) begin failures++; $display("FAIL valid_latency got=%0d exp=%0d", validCyc - startCyc, EXP_LAT); end
    checks++; if (busIf.busy !== 1'b0) begin failures++; $display("FAIL valid_busy_idle got=%b exp=0", busIf.busy); end
  endtask

  task automatic test_back_to_back();
    int v0;
    logic [NUM_SIZE-1:0] expv, gotv;
    v0 = validCount;
    exp_q.push_back(7'd64);
    exp_q.push_back(7'd96);
    send_frame(4'b0100, 7'd64, BIT_CLKS, 1'b0);
    checks++; if (busIf.phase_num !== 7'd64) begin failures++; $display("FAIL b2b_first got=%0d exp=64", busIf.phase_num); end
    drive_bit(1'b0, BIT_CLKS);
    send_frame(4'b0100, 7'd96, BIT_CLKS, 1'b0);
    drive_bit(1'b0, 2 * BIT_CLKS);
    checks++; if (validCount - v0 !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", validCount - v0); end
    for (int k = 0; k < 2; k++) begin
      expv = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL b2b_word%0d got=none exp=%0d", k, expv); end
      else begin
        gotv = got_q.pop_front();
        if (gotv !== expv) begin failures++; $display("FAIL b2b_word%0d got=%0d exp=%0d", k, gotv, expv); end
      end
    end
    checks++; if (busIf.phase_num !== 7'd96) begin failures++; $display("FAIL b2b_hold got=%0d exp=96", busIf.phase_num); end
  endtask

  task automatic test_bad_header();
    int v0, e0;
    v0 = validCount; e0 = errCount;
    send_frame(4'b0110, 7'd127, BIT_CLKS, 1'b0);
    drive_bit(1'b0, 2 * BIT_CLKS);
    checks++; if (errCount - e0 !== 1) begin failures++; $display("FAIL badhdr_err got=%0d exp=1", errCount - e0); end
    checks++; if (validCount !== v0) begin failures++; $display("FAIL badhdr_valid got=%0d exp=0", validCount - v0); end
    checks++; if (busIf.phase_num !== 7'd96) begin failures++; $display("FAIL badhdr_hold got=%0d exp=96", busIf.phase_num); end
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = validCount; e0 = errCount;
    drive_bit(1'b1, 20);
    checks++; if (busIf.busy !== 1'b1) begin failures++; $display("FAIL glitch_busy got=%b exp=1", busIf.busy); end
    drive_bit(1'b1, 80);
    drive_bit(1'b0, BIT_CLKS);
    checks++; if (busIf.busy !== 1'b0) begin failures++; $display("FAIL glitch_idle got=%b exp=0", busIf.busy); end
    checks++; if (validCount !== v0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", validCount - v0); end
    checks++; if (errCount !== e0) begin failures++; $display("FAIL glitch_err got=%0d exp=0", errCount - e0); end
  endtask

  task automatic test_bit_skew();
    int v0, e0;
    int widths[2];
    widths[0] = BIT_CLKS + BIT_CLKS * 31 / 1024;
    widths[1] = BIT_CLKS - BIT_CLKS * 34 / 1024;
    for (int k = 0; k < 2; k++) begin
      v0 = validCount; e0 = errCount;
      busIf.decoderInput = 1'b0;
      drive_bit(1'b0, 4);
      send_frame(4'b0100, 7'd0, BIT_CLKS, 1'b0);
      drive_bit(1'b0, BIT_CLKS);
      send_frame(4'b0100, 7'd127, widths[k], 1'b0);
      drive_bit(1'b0, 2 * BIT_CLKS);
      checks++; if (validCount - v0 !== 2) begin failures++; $display("FAIL skew%0d_count got=%0d exp=2", k, validCount - v0); end
      checks++; if (errCount !== e0) begin failures++; $display("FAIL skew%0d_err got=%0d exp=0", k, errCount - e0); end
      checks++; if (busIf.phase_num !== 7'd127) begin failures++; $display("FAIL skew%0d_word got=%0d exp=127", k, busIf.phase_num); end
      got_q.delete();
    end
  endtask

  task automatic test_rearm_hold_high();
    int v0, e0;
    logic busySeen;
    v0 = validCount; e0 = errCount;
    busySeen = 1'b0;
    send_frame(4'b0100, 7'd3, BIT_CLKS, 1'b0);
    busIf.decoderInput = 1'b1;
    for (int i = 0; i < 2 * BIT_CLKS; i++) begin
      @(negedge clk);
      if (busIf.busy) busySeen = 1'b1;
    end
    checks++; if (busySeen !== 1'b0) begin failures++; $display("FAIL rearm_busy got=1 exp=0"); end
    checks++; if (validCount - v0 !== 1) begin failures++; $display("FAIL rearm_count got=%0d exp=1", validCount - v0); end
    checks++; if (errCount !== e0) begin failures++; $display("FAIL rearm_err got=%0d exp=0", errCount - e0); end
    checks++; if (busIf.phase_num !== 7'd3) begin failures++; $display("FAIL rearm_word got=%0d exp=3", busIf.phase_num); end
    @(posedge clk);
    #1;
    drive_bit(1'b0, 2 * BIT_CLKS);
    got_q.delete();
  endtask

  task automatic test_parity();
`ifdef DECODER_PARITY_EN
    int v0, e0;
    v0 = validCount; e0 = errCount;
    send_frame(4'b0100, 7'd45, BIT_CLKS, 1'b1);
    drive_bit(1'b0, 2 * BIT_CLKS);
    checks++; if (errCount - e0 !== 1) begin failures++; $display("FAIL parity_bad_err got=%0d exp=1", errCount - e0); end
    checks++; if (validCount !== v0) begin failures++; $display("FAIL parity_bad_valid got=%0d exp=0", validCount - v0); end
    checks++; if (busIf.phase_num !== 7'd3) begin failures++; $display("FAIL parity_bad_hold got=%0d exp=3", busIf.phase_num); end
    send_frame(4'b0100, 7'd45, BIT_CLKS, 1'b0);
    drive_bit(1'b0, 2 * BIT_CLKS);
    checks++; if (validCount - v0 !== 1) begin failures++; $display("FAIL parity_ok_valid got=%0d exp=1", validCount - v0); end
    checks++; if (busIf.phase_num !== 7'd45) begin failures++; $display("FAIL parity_ok_word got=%0d exp=45", busIf.phase_num); end
    got_q.delete();
`endif
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    drive_bit(1'b1, BIT_CLKS);
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS / 3);
    checks++; if (busIf.busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busIf.busy); end
    rst = 1'b1;
    #1;
    checks++; if (busIf.phase_num !== 7'd0) begin failures++; $display("FAIL midrst_phase got=%0d exp=0", busIf.phase_num); end
    checks++; if (busIf.num_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", busIf.num_valid); end
    checks++; if (busIf.frame_err !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", busIf.frame_err); end
    checks++; if (busIf.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busIf.busy); end
    busIf.decoderInput = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    drive_bit(1'b0, BIT_CLKS);
    v0 = validCount;
    send_frame(4'b0100, 7'd5, BIT_CLKS, 1'b0);
    drive_bit(1'b0, 2 * BIT_CLKS);
    checks++; if (validCount - v0 !== 1) begin failures++; $display("FAIL midrst_recover_count got=%0d exp=1", validCount - v0); end
    checks++; if (busIf.phase_num !== 7'd5) begin failures++; $display("FAIL midrst_recover_word got=%0d exp=5", busIf.phase_num); end
  endtask

  task automatic test_pulse_integrity();
    checks++; if (bothHigh !== 1'b0) begin failures++; $display("FAIL strobe_overlap got=1 exp=0"); end
    checks++; if (longPulse !== 1'b0) begin failures++; $display("FAIL strobe_width got=multi exp=single"); end
  endtask

  initial begin
    busIf.decoderInput = 1'b0;
    test_reset();
    test_valid_frame();
    test_back_to_back();
    test_bad_header();
    test_glitch();
    test_bit_skew();
    test_rearm_hold_high();
    test_parity();
    test_reset_mid_frame();
    test_pulse_integrity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
